// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register (hold / shift right / shift left / load) with a
// word counter that pulses word_done every WIDTH shifts. Define USR_ROTATE_EN to add rot.
module universal_shift_reg #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] in,
   input  logic             sin_r,
   input  logic             sin_l,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] out,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    shift_cnt,
   output logic             word_done
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHR   = 2'b01;
   localparam logic [1:0] MODE_SHL   = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] out_q, out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             fill_r, fill_l;
   logic             shifting;

   // Bits entering the register on a shift: serial inputs, or the wrapped-around bit when rotating
`ifdef USR_ROTATE_EN
   assign fill_r = rot ? out_q[0]       : sin_r;
   assign fill_l = rot ? out_q[WIDTH-1] : sin_l;
`else
   assign fill_r = sin_r;
   assign fill_l = sin_l;
`endif

   always_comb begin
      out_d    = out_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shifting = 1'b0;
      if (en) begin
         case (mode)
            MODE_HOLD: ;
            MODE_SHR: begin
               out_d    = {fill_r, out_q[WIDTH-1:1]};
               shifting = 1'b1;
            end
            MODE_SHL: begin
               out_d    = {out_q[WIDTH-2:0], fill_l};
               shifting = 1'b1;
            end
            MODE_LOAD: begin
               out_d = in;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Counter keeps running across direction changes; only load, wrap or reset clear it
      if (shifting) begin
         if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         out_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign out       = out_q;
   assign shift_cnt = cnt_q;
   assign word_done = done_q;
   assign sout_r    = out_q[0];
   assign sout_l    = out_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomised and directed bench for universal_shift_reg (WIDTH=4) against an arithmetic
// reference model; exercises rot too when USR_ROTATE_EN is defined.
module tb_universal_shift_reg;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CW    = 2;

   logic             clk = 1'b0;
   logic             clr;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] in;
   logic             sin_r;
   logic             sin_l;
   logic             rot_v;
`ifdef USR_ROTATE_EN
   logic             rot;
   assign rot = rot_v;
`endif
   logic [WIDTH-1:0] out;
   logic             sout_r;
   logic             sout_l;
   logic [CW-1:0]    shift_cnt;
   logic             word_done;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   // Reference model: register value as a number, count of shifts since last clear
   logic [WIDTH-1:0] m_out;
   int               m_cnt;
   logic             m_done;

   universal_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .mode      (mode),
      .in        (in),
      .sin_r     (sin_r),
      .sin_l     (sin_l),
`ifdef USR_ROTATE_EN
      .rot       (rot),
`endif
      .out       (out),
      .sout_r    (sout_r),
      .sout_l    (sout_l),
      .shift_cnt (shift_cnt),
      .word_done (word_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      m_out  = '0;
      m_cnt  = 0;
      m_done = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs present before the edge
   task automatic model_edge();
      logic b;
      m_done = 1'b0;
      if (!clr) begin
         model_clear();
      end else if (en) begin
         if (mode == 2'b11) begin
            m_out = in;
            m_cnt = 0;
         end else if (mode == 2'b01 || mode == 2'b10) begin
            if (mode == 2'b01) begin
               b     = rot_v ? m_out[0] : sin_r;
               m_out = (m_out >> 1) | (WIDTH'(b) << (WIDTH - 1));
            end else begin
               b     = rot_v ? m_out[WIDTH-1] : sin_l;
               m_out = (m_out << 1) | WIDTH'(b);
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == WIDTH) begin
               m_cnt  = 0;
               m_done = 1'b1;
            end
         end
      end
   endtask

   // Compare process: every falling edge the DUT must match the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("out",       32'(out),       32'(m_out));
         check("sout_r",    32'(sout_r),    32'(m_out[0]));
         check("sout_l",    32'(sout_l),    32'(m_out[WIDTH-1]));
         check("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
         check("word_done", 32'(word_done), 32'(m_done));
      end
   end

   // Drive inputs (called at posedge+1), take one edge, return at posedge+1
   task automatic cyc(input logic e, input logic [1:0] md, input logic [WIDTH-1:0] d,
                      input logic sr, input logic sl);
      en    = e;
      mode  = md;
      in    = d;
      sin_r = sr;
      sin_l = sl;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic async_reset_pulse();
      #1;
      clr = 1'b0;
      model_clear();
      #1;
      check("async_clr_out", 32'(out),       32'h0);
      check("async_clr_cnt", 32'(shift_cnt), 32'h0);
      check("async_clr_sout", 32'({sout_l, sout_r}), 32'h0);
      clr = 1'b1;
   endtask

   logic [3:0] exp_sr [4];
   logic [1:0] exp_cnt [8];

   initial begin
      clr   = 1'b0;
      en    = 1'b0;
      mode  = 2'b00;
      in    = '0;
      sin_r = 1'b0;
      sin_l = 1'b0;
      rot_v = 1'b0;
      model_clear();
      chk_on = 1'b1;

      // Reset held while clock and data toggle
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         in   = WIDTH'($urandom);
         en   = 1'b1;
         mode = 2'b11;
         check("reset_hold_out", 32'(out), 32'h0);
      end
      clr = 1'b1;
      cyc(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0);
      check("first_load", 32'(out), 32'hA);

      // Load 1011, shift right with sin_r 0,1,1,0
      exp_sr = '{4'b0101, 4'b1010, 4'b1101, 4'b0110};
      cyc(1'b1, 2'b11, 4'b1011, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] srin;
         logic [3:0] srout;
         srin  = 4'b0110;
         srout = 4'b1011;
         check("sout_r_seq", 32'(sout_r), 32'(srout[i]));
         cyc(1'b1, 2'b01, '0, srin[i], 1'b0);
         check("shr_out", 32'(out), 32'(exp_sr[i]));
         check("shr_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
      end
      cyc(1'b1, 2'b00, '0, 1'b0, 1'b0);
      check("done_one_cycle", 32'(word_done), 32'h0);

      // Shift left 8 with sin_l=1 from zero
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      cyc(1'b1, 2'b11, 4'b0000, 1'b0, 1'b0);
      check("shl_cnt_start", 32'(shift_cnt), 32'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 2'b10, '0, 1'b0, 1'b1);
         check("shl_cnt", 32'(shift_cnt), 32'(exp_cnt[i]));
         check("shl_done", 32'(word_done), (i == 3 || i == 7) ? 32'h1 : 32'h0);
         if (i == 3) check("shl_full", 32'(out), 32'hF);
      end

      // Load 0101, two shifts, three disabled cycles, two more shifts
      cyc(1'b1, 2'b11, 4'b0101, 1'b0, 1'b0);
      cyc(1'b1, 2'b01, '0, 1'b0, 1'b0);
      cyc(1'b1, 2'b01, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 2'b01, 4'hF, 1'b1, 1'b1);
         check("en_hold_out", 32'(out), 32'h1);
         check("en_hold_done", 32'(word_done), 32'h0);
      end
      cyc(1'b1, 2'b01, '0, 1'b0, 1'b0);
      check("en_resume_done3", 32'(word_done), 32'h0);
      cyc(1'b1, 2'b01, '0, 1'b0, 1'b0);
      check("en_resume_done4", 32'(word_done), 32'h1);

      // Reset mid-word discards the partial count
      cyc(1'b1, 2'b10, '0, 1'b0, 1'b1);
      cyc(1'b1, 2'b10, '0, 1'b0, 1'b1);
      en = 1'b0;
      async_reset_pulse();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'b01, '0, 1'b1, 1'b0);
         check("post_reset_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
      end

`ifdef USR_ROTATE_EN
      // Rotate left: the MSB wraps round to the LSB
      cyc(1'b1, 2'b11, 4'b1000, 1'b0, 1'b0);
      rot_v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 2'b10, '0, 1'b0, 1'b0);
         check("rotl_out", 32'(out), 32'(4'b0001 << i));
         check("rotl_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
      end
      rot_v = 1'b0;
`endif

      // Randomised traffic, biased towards shifting, with occasional async reset
      for (int i = 0; i < 3000; i++) begin
`ifdef USR_ROTATE_EN
         rot_v = 1'($urandom_range(0, 3) == 0);
`endif
         cyc(1'($urandom_range(0, 7) != 0),
             ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom),
             WIDTH'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 99) == 0) async_reset_pulse();
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
